frame_buffer_scan_controller: RTL and testbench
===============================================

Name: frame_buffer_scan_controller

Overview:
- Initiator for the frame_buffer_o_matrix3 write/read port. Accepts a raster-order grayscale pixel stream.
- Writes each pixel into the 3-row rolling buffer at the proper (column, row), then issues a read for every interior centre pixel whose 3x3 neighbourhood is complete.
- Delivers a valid strobe plus frame coordinates aligned with the buffer's O_PIXEL_MATRIX, so the downstream edge-detection kernel can consume matrices directly.

Parameters:
- P_COLUMNS, 640: pixels per image row; also the frame buffer column count.
- P_ROWS, 3: frame buffer rows (rolling line buffer depth); fixed at 3.
- P_FRAME_ROWS, 480: image rows per frame.
- P_PIXEL_DEPTH, 8: bits per pixel.
- P_READ_LATENCY, 1: cycles from O_READ_ENABLE to a valid O_PIXEL_MATRIX at the buffer; legal range 1..4.

Ports:
- I_CLK  in  1  clock.
- I_RESET  in  1  asynchronous, active-low reset.
- I_PIXEL  in  P_PIXEL_DEPTH  incoming stream pixel.
- I_PIXEL_VALID  in  1  I_PIXEL valid.
- O_PIXEL_READY  out  1  controller can accept a pixel this cycle.
- O_COLUMN  out  $clog2(P_COLUMNS)  buffer column address.
- O_ROW  out  $clog2(P_ROWS)  buffer row address.
- O_PIXEL  out  P_PIXEL_DEPTH  write data to buffer.
- O_WRITE_ENABLE  out  1  buffer write strobe.
- O_READ_ENABLE  out  1  buffer read strobe.
- O_MATRIX_VALID  out  1  buffer O_PIXEL_MATRIX is valid this cycle.
- O_CENTER_COLUMN  out  $clog2(P_COLUMNS)  image column of the matrix centre.
- O_CENTER_ROW  out  $clog2(P_FRAME_ROWS)  image row of the matrix centre.
- O_FRAME_DONE  out  1  one-cycle pulse after the last read of a frame is issued.

Behaviour:
- Reset (asynchronous, I_RESET=0):
  - All outputs 0, state S_ACCEPT, all counters 0, latency pipe cleared.
  - An in-flight read is discarded, with no O_MATRIX_VALID.
- Counters: col (0..P_COLUMNS-1), frame_row fr (0..P_FRAME_ROWS-1), buffer row wr (0..2).
  - col wraps to 0 at P_COLUMNS-1, which increments fr and wr.
  - wr wraps 2->0. fr wraps at P_FRAME_ROWS-1; wr is not reset at frame wrap.
- FSM:
  - S_ACCEPT:
    - O_PIXEL_READY=1.
    - On I_PIXEL_VALID, latch pixel and (col, wr), then go to S_WRITE.
  - S_WRITE:
    - O_WRITE_ENABLE=1, O_COLUMN=col, O_ROW=wr, O_PIXEL=latched.
    - If a read is due, go to S_READ. Otherwise advance counters and return to S_ACCEPT.
  - S_READ:
    - O_READ_ENABLE=1, O_COLUMN=col-1, O_ROW=(wr+2) mod 3.
    - Push (col-1, fr-1) into the latency pipe, advance counters, return to S_ACCEPT.
- Read-due condition: fr>=2 and col>=2.
  - Border centres (image row 0 / last row, column 0 / last column) are never read.
  - Last read of a row has centre column P_COLUMNS-2, issued when col=P_COLUMNS-1.
- Strobes: O_WRITE_ENABLE and O_READ_ENABLE are never both 1. Each is a one-cycle pulse.
- Throughput: 2 cycles per pixel with no read, 3 cycles with a read. O_PIXEL_READY=0 outside S_ACCEPT.
- Latency pipe: O_MATRIX_VALID, O_CENTER_COLUMN and O_CENTER_ROW appear exactly P_READ_LATENCY cycles after the matching O_READ_ENABLE.
  - Coordinates hold their last value when not valid.
- O_FRAME_DONE: pulses in the cycle after the S_READ of centre (P_COLUMNS-2, P_FRAME_ROWS-2).
- Address outputs are don't-care when both strobes are 0; they are driven 0.
- Width arithmetic:
  - col-1 uses column width and cannot underflow, because it only occurs when col>=2.
  - (wr+2) mod 3 is computed by lookup: 0->2, 1->0, 2->1.

Optional Feature:
- Macro FRAME_BUFFER_SCAN_SOF_EN.
- Defined:
  - Adds input I_START_OF_FRAME (1 bit), sampled with an accepted pixel.
  - When 1, that pixel is forced to col=0, fr=0, wr=0 (resynchronisation).
  - The latency pipe is not flushed.
  - O_FRAME_DONE also pulses if SOF arrives with fr>=2 (truncated frame).
- Undefined: port absent; counters free-run as above.

Decomposition:
- Package frame_buffer_scan_pkg:
  - state enum (S_ACCEPT, S_WRITE, S_READ);
  - localparams for column/row/frame-row widths;
  - a function prev_buffer_row(wr).
- One sub-module: frame_buffer_scan_latency_pipe.
  - Parameterised shift register of {valid, column, row}, depth P_READ_LATENCY, async active-low clear.

Test Plan:
- Bench parameters: P_COLUMNS=4, P_FRAME_ROWS=4, P_READ_LATENCY=1.
- Reset, then 8 pixels (rows 0-1) -> 8 write pulses at (0..3, 0) and (0..3, 1); no O_READ_ENABLE; O_MATRIX_VALID stays 0.
- Row 2 pixels 0x10..0x13 -> reads at col=2 and 3, addressing (1,1) and (2,1) -> O_MATRIX_VALID 1 cycle later with centres (1,1) and (2,1).
- Row 3 -> writes land in O_ROW=0 (wrap), reads address O_ROW=2 -> centres (1,2) and (2,2), then O_FRAME_DONE a single pulse.
- Stall I_PIXEL_VALID=0 for 5 cycles mid-row -> no strobes, counters hold; resume gives continuous addresses.
- Assert I_RESET=0 in the cycle after an S_READ -> O_MATRIX_VALID never rises; after release, first write is at (0,0).
- With FRAME_BUFFER_SCAN_SOF_EN defined, SOF on the 6th pixel -> that write at (0,0), O_FRAME_DONE=0 because fr<2, and the next 8 pixels produce no read.

Source files
------------

// File: rtl/frame_buffer_scan_pkg.sv
// Shared types and helpers for the frame buffer scan controller.
// Optional start-of-frame resync is enabled by FRAME_BUFFER_SCAN_SOF_EN.
package frame_buffer_scan_pkg;

   typedef enum logic [1:0] {
      S_ACCEPT = 2'd0,
      S_WRITE  = 2'd1,
      S_READ   = 2'd2
   } state_e;

   localparam int DEF_COLUMNS    = 640;
   localparam int DEF_FRAME_ROWS = 480;
   localparam int BUF_ROWS       = 3;
   localparam int COL_W          = $clog2(DEF_COLUMNS);
   localparam int ROW_W          = $clog2(BUF_ROWS);
   localparam int FROW_W         = $clog2(DEF_FRAME_ROWS);

   // Buffer row holding the image row above the one being written: (wr+2) mod 3.
   function automatic logic [ROW_W-1:0] prev_buffer_row(input logic [ROW_W-1:0] wr);
      case (wr)
         2'd0:    return 2'd2;
         2'd1:    return 2'd0;
         2'd2:    return 2'd1;
         default: return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/frame_buffer_scan_controller_if.sv
// Pixel stream in, frame buffer write/read port and matrix-valid side-band out.
// I_START_OF_FRAME exists only when FRAME_BUFFER_SCAN_SOF_EN is defined.
interface frame_buffer_scan_controller_if #(
   parameter int P_COLUMNS     = 640,
   parameter int P_ROWS        = 3,
   parameter int P_FRAME_ROWS  = 480,
   parameter int P_PIXEL_DEPTH = 8
);
   localparam int CW = $clog2(P_COLUMNS);
   localparam int RW = $clog2(P_ROWS);
   localparam int FW = $clog2(P_FRAME_ROWS);

   logic [P_PIXEL_DEPTH-1:0] I_PIXEL;
   logic                     I_PIXEL_VALID;
`ifdef FRAME_BUFFER_SCAN_SOF_EN
   logic                     I_START_OF_FRAME;
`endif
   logic                     O_PIXEL_READY;
   logic [CW-1:0]            O_COLUMN;
   logic [RW-1:0]            O_ROW;
   logic [P_PIXEL_DEPTH-1:0] O_PIXEL;
   logic                     O_WRITE_ENABLE;
   logic                     O_READ_ENABLE;
   logic                     O_MATRIX_VALID;
   logic [CW-1:0]            O_CENTER_COLUMN;
   logic [FW-1:0]            O_CENTER_ROW;
   logic                     O_FRAME_DONE;

   modport master (
`ifdef FRAME_BUFFER_SCAN_SOF_EN
      input  I_START_OF_FRAME,
`endif
      input  I_PIXEL, I_PIXEL_VALID,
      output O_PIXEL_READY, O_COLUMN, O_ROW, O_PIXEL, O_WRITE_ENABLE, O_READ_ENABLE,
             O_MATRIX_VALID, O_CENTER_COLUMN, O_CENTER_ROW, O_FRAME_DONE
   );

   modport slave (
`ifdef FRAME_BUFFER_SCAN_SOF_EN
      output I_START_OF_FRAME,
`endif
      output I_PIXEL, I_PIXEL_VALID,
      input  O_PIXEL_READY, O_COLUMN, O_ROW, O_PIXEL, O_WRITE_ENABLE, O_READ_ENABLE,
             O_MATRIX_VALID, O_CENTER_COLUMN, O_CENTER_ROW, O_FRAME_DONE
   );

endinterface

// File: rtl/frame_buffer_scan_latency_pipe.sv
// Delays {valid, centre column, centre row} by DEPTH cycles to line up with buffer read data.
// Coordinates only move with a valid entry, so the outputs hold the last valid centre.
module frame_buffer_scan_latency_pipe #(
   parameter int DEPTH = 1,
   parameter int COL_W = 10,
   parameter int ROW_W = 9
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [COL_W-1:0] push_col,
   input  logic [ROW_W-1:0] push_row,
   output logic             valid,
   output logic [COL_W-1:0] col,
   output logic [ROW_W-1:0] row
);

   logic [DEPTH-1:0]            vld_pipe;
   logic [DEPTH-1:0][COL_W-1:0] col_pipe;
   logic [DEPTH-1:0][ROW_W-1:0] row_pipe;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         col_pipe <= '0;
         row_pipe <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (i == 0) begin
               vld_pipe[0] <= push;
               if (push) begin
                  col_pipe[0] <= push_col;
                  row_pipe[0] <= push_row;
               end
            end else begin
               vld_pipe[i] <= vld_pipe[i-1];
               if (vld_pipe[i-1]) begin
                  col_pipe[i] <= col_pipe[i-1];
                  row_pipe[i] <= row_pipe[i-1];
               end
            end
         end
      end
   end

   assign valid = vld_pipe[DEPTH-1];
   assign col   = col_pipe[DEPTH-1];
   assign row   = row_pipe[DEPTH-1];

endmodule

// File: rtl/frame_buffer_scan_controller.sv
// Raster pixel stream -> 3-row rolling frame buffer writes plus 3x3 neighbourhood reads.
// Define FRAME_BUFFER_SCAN_SOF_EN to add I_START_OF_FRAME counter resynchronisation.
module frame_buffer_scan_controller
   import frame_buffer_scan_pkg::*;
#(
   parameter int P_COLUMNS      = 640,
   parameter int P_ROWS         = 3,
   parameter int P_FRAME_ROWS   = 480,
   parameter int P_PIXEL_DEPTH  = 8,
   parameter int P_READ_LATENCY = 1
) (
   input logic I_CLK,
   input logic I_RESET,
   frame_buffer_scan_controller_if.master bus
);

   localparam int CW = $clog2(P_COLUMNS);
   localparam int RW = $clog2(P_ROWS);
   localparam int FW = $clog2(P_FRAME_ROWS);
   localparam logic [CW-1:0] COL_LAST = CW'(P_COLUMNS - 1);
   localparam logic [FW-1:0] FR_LAST  = FW'(P_FRAME_ROWS - 1);
   localparam logic [RW-1:0] WR_LAST  = RW'(2);

   state_e                   state;
   logic [CW-1:0]            col, col_nxt, ctr_col;
   logic [FW-1:0]            fr, fr_nxt, ctr_row;
   logic [RW-1:0]            wr, wr_nxt;
   logic                     ready_q, we_q, re_q, done_q;
   logic [CW-1:0]            addr_col_q;
   logic [RW-1:0]            addr_row_q;
   logic [P_PIXEL_DEPTH-1:0] pix_q;
   logic                     read_due;

   assign read_due = (fr >= FW'(2)) && (col >= CW'(2));

   always_comb begin
      col_nxt = col + 1'b1;
      fr_nxt  = fr;
      wr_nxt  = wr;
      if (col == COL_LAST) begin
         col_nxt = '0;
         fr_nxt  = (fr == FR_LAST) ? '0 : fr + 1'b1;
         wr_nxt  = (wr == WR_LAST) ? '0 : wr + 1'b1;
      end
   end

   always_ff @(posedge I_CLK or negedge I_RESET) begin
      if (!I_RESET) begin
         state      <= S_ACCEPT;
         col        <= '0;
         fr         <= '0;
         wr         <= '0;
         ready_q    <= 1'b0;
         we_q       <= 1'b0;
         re_q       <= 1'b0;
         done_q     <= 1'b0;
         addr_col_q <= '0;
         addr_row_q <= '0;
         pix_q      <= '0;
         ctr_col    <= '0;
         ctr_row    <= '0;
      end else begin
         done_q <= 1'b0;
         case (state)
            S_ACCEPT: begin
               if (ready_q && bus.I_PIXEL_VALID) begin
                  state   <= S_WRITE;
                  ready_q <= 1'b0;
                  we_q    <= 1'b1;
                  pix_q   <= bus.I_PIXEL;
`ifdef FRAME_BUFFER_SCAN_SOF_EN
                  if (bus.I_START_OF_FRAME) begin
                     // Resync: this pixel becomes (0,0); a frame cut short still reports done.
                     col        <= '0;
                     fr         <= '0;
                     wr         <= '0;
                     addr_col_q <= '0;
                     addr_row_q <= '0;
                     done_q     <= (fr >= FW'(2));
                  end else begin
                     addr_col_q <= col;
                     addr_row_q <= wr;
                  end
`else
                  addr_col_q <= col;
                  addr_row_q <= wr;
`endif
               end else begin
                  ready_q <= 1'b1;
               end
            end
            S_WRITE: begin
               we_q  <= 1'b0;
               pix_q <= '0;
               if (read_due) begin
                  // Centre is one column back, one image row up.
                  state      <= S_READ;
                  re_q       <= 1'b1;
                  addr_col_q <= col - 1'b1;
                  addr_row_q <= prev_buffer_row(wr);
                  ctr_col    <= col - 1'b1;
                  ctr_row    <= fr - 1'b1;
               end else begin
                  state      <= S_ACCEPT;
                  ready_q    <= 1'b1;
                  addr_col_q <= '0;
                  addr_row_q <= '0;
                  col        <= col_nxt;
                  fr         <= fr_nxt;
                  wr         <= wr_nxt;
               end
            end
            S_READ: begin
               state      <= S_ACCEPT;
               ready_q    <= 1'b1;
               re_q       <= 1'b0;
               addr_col_q <= '0;
               addr_row_q <= '0;
               done_q     <= (col == COL_LAST) && (fr == FR_LAST);
               col        <= col_nxt;
               fr         <= fr_nxt;
               wr         <= wr_nxt;
            end
            default: begin
               state   <= S_ACCEPT;
               ready_q <= 1'b0;
               we_q    <= 1'b0;
               re_q    <= 1'b0;
            end
         endcase
      end
   end

   frame_buffer_scan_latency_pipe #(
      .DEPTH (P_READ_LATENCY),
      .COL_W (CW),
      .ROW_W (FW)
   ) u_latency_pipe (
      .clk      (I_CLK),
      .rst_n    (I_RESET),
      .push     (re_q),
      .push_col (ctr_col),
      .push_row (ctr_row),
      .valid    (bus.O_MATRIX_VALID),
      .col      (bus.O_CENTER_COLUMN),
      .row      (bus.O_CENTER_ROW)
   );

   assign bus.O_PIXEL_READY  = ready_q;
   assign bus.O_WRITE_ENABLE = we_q;
   assign bus.O_READ_ENABLE  = re_q;
   assign bus.O_COLUMN       = addr_col_q;
   assign bus.O_ROW          = addr_row_q;
   assign bus.O_PIXEL        = pix_q;
   assign bus.O_FRAME_DONE   = done_q;

endmodule

// File: tb/tb_frame_buffer_scan_controller.sv
// Directed bench for frame_buffer_scan_controller at 4x4 frames, read latency 1.
// SOF resync steps run only when FRAME_BUFFER_SCAN_SOF_EN is defined.
module tb_frame_buffer_scan_controller;

   localparam int C = 4;
   localparam int F = 4;

   logic I_CLK = 1'b0;
   logic I_RESET = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 I_CLK = ~I_CLK;

   frame_buffer_scan_controller_if #(
      .P_COLUMNS(C), .P_ROWS(3), .P_FRAME_ROWS(F), .P_PIXEL_DEPTH(8)
   ) bus ();

   frame_buffer_scan_controller #(
      .P_COLUMNS(C), .P_ROWS(3), .P_FRAME_ROWS(F), .P_PIXEL_DEPTH(8), .P_READ_LATENCY(1)
   ) dut (
      .I_CLK   (I_CLK),
      .I_RESET (I_RESET),
      .bus     (bus.master)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic set_sof(input logic s);
`ifdef FRAME_BUFFER_SCAN_SOF_EN
      bus.I_START_OF_FRAME = s;
`else
      if (s) chk("sof_unsupported", 32'd1, 32'd0);
`endif
   endtask

   // Called at a negedge with the controller idle in S_ACCEPT; returns at the negedge
   // after the transaction, idle again.
   task automatic send(input logic [7:0] pix, input logic sof, input int wc, input int wrow,
                       input logic wdone, input logic rd, input int rc, input int rrow,
                       input int crow, input logic done);
      chk("ready_before", 32'(bus.O_PIXEL_READY), 32'd1);
      bus.I_PIXEL = pix;
      bus.I_PIXEL_VALID = 1'b1;
      set_sof(sof);
      @(negedge I_CLK);
      bus.I_PIXEL_VALID = 1'b0;
      set_sof(1'b0);
      chk("wr_en", 32'(bus.O_WRITE_ENABLE), 32'd1);
      chk("wr_rd_en", 32'(bus.O_READ_ENABLE), 32'd0);
      chk("wr_col", 32'(bus.O_COLUMN), 32'(wc));
      chk("wr_row", 32'(bus.O_ROW), 32'(wrow));
      chk("wr_pixel", 32'(bus.O_PIXEL), 32'(pix));
      chk("wr_ready", 32'(bus.O_PIXEL_READY), 32'd0);
      chk("wr_done", 32'(bus.O_FRAME_DONE), 32'(wdone));
      @(negedge I_CLK);
      if (rd) begin
         chk("rd_en", 32'(bus.O_READ_ENABLE), 32'd1);
         chk("rd_wr_en", 32'(bus.O_WRITE_ENABLE), 32'd0);
         chk("rd_col", 32'(bus.O_COLUMN), 32'(rc));
         chk("rd_row", 32'(bus.O_ROW), 32'(rrow));
         @(negedge I_CLK);
         chk("mv", 32'(bus.O_MATRIX_VALID), 32'd1);
         chk("ctr_col", 32'(bus.O_CENTER_COLUMN), 32'(rc));
         chk("ctr_row", 32'(bus.O_CENTER_ROW), 32'(crow));
         chk("done", 32'(bus.O_FRAME_DONE), 32'(done));
         chk("rd_en_pulse", 32'(bus.O_READ_ENABLE), 32'd0);
      end else begin
         chk("no_rd_en", 32'(bus.O_READ_ENABLE), 32'd0);
         chk("no_wr_en", 32'(bus.O_WRITE_ENABLE), 32'd0);
         chk("no_mv", 32'(bus.O_MATRIX_VALID), 32'd0);
         chk("no_done", 32'(bus.O_FRAME_DONE), 32'd0);
      end
   endtask

   task automatic do_reset();
      I_RESET = 1'b0;
      repeat (2) @(negedge I_CLK);
      chk("rst_ready", 32'(bus.O_PIXEL_READY), 32'd0);
      chk("rst_we", 32'(bus.O_WRITE_ENABLE), 32'd0);
      chk("rst_re", 32'(bus.O_READ_ENABLE), 32'd0);
      chk("rst_mv", 32'(bus.O_MATRIX_VALID), 32'd0);
      chk("rst_done", 32'(bus.O_FRAME_DONE), 32'd0);
      chk("rst_col", 32'(bus.O_COLUMN), 32'd0);
      chk("rst_ctr_col", 32'(bus.O_CENTER_COLUMN), 32'd0);
      I_RESET = 1'b1;
      @(negedge I_CLK);
   endtask

   initial begin
      bus.I_PIXEL = '0;
      bus.I_PIXEL_VALID = 1'b0;
      set_sof(1'b0);
      do_reset();

      // Rows 0-1: writes only.
      for (int i = 0; i < 8; i++)
         send(8'(i), 1'b0, i % 4, i / 4, 1'b0, 1'b0, 0, 0, 0, 1'b0);

      // Row 2 (buffer row 2): reads of the row-1 centres.
      send(8'h10, 1'b0, 0, 2, 1'b0, 1'b0, 0, 0, 0, 1'b0);
      send(8'h11, 1'b0, 1, 2, 1'b0, 1'b0, 0, 0, 0, 1'b0);
      send(8'h12, 1'b0, 2, 2, 1'b0, 1'b1, 1, 1, 1, 1'b0);
      send(8'h13, 1'b0, 3, 2, 1'b0, 1'b1, 2, 1, 1, 1'b0);

      // Row 3 wraps to buffer row 0; the last read ends the frame.
      send(8'h20, 1'b0, 0, 0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
      send(8'h21, 1'b0, 1, 0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
      send(8'h22, 1'b0, 2, 0, 1'b0, 1'b1, 1, 2, 2, 1'b0);
      send(8'h23, 1'b0, 3, 0, 1'b0, 1'b1, 2, 2, 2, 1'b1);
      chk("done_pulse", 32'(bus.O_FRAME_DONE), 32'd1);
      @(negedge I_CLK);
      chk("done_one_cycle", 32'(bus.O_FRAME_DONE), 32'd0);

      // Next frame row 0 lands in buffer row 1; stall mid-row.
      send(8'h30, 1'b0, 0, 1, 1'b0, 1'b0, 0, 0, 0, 1'b0);
      send(8'h31, 1'b0, 1, 1, 1'b0, 1'b0, 0, 0, 0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge I_CLK);
         chk("stall_we", 32'(bus.O_WRITE_ENABLE), 32'd0);
         chk("stall_re", 32'(bus.O_READ_ENABLE), 32'd0);
         chk("stall_ready", 32'(bus.O_PIXEL_READY), 32'd1);
      end
      send(8'h32, 1'b0, 2, 1, 1'b0, 1'b0, 0, 0, 0, 1'b0);
      send(8'h33, 1'b0, 3, 1, 1'b0, 1'b0, 0, 0, 0, 1'b0);
      for (int i = 0; i < 4; i++)
         send(8'h40 + 8'(i), 1'b0, i, 2, 1'b0, 1'b0, 0, 0, 0, 1'b0);
      send(8'h50, 1'b0, 0, 0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
      send(8'h51, 1'b0, 1, 0, 1'b0, 1'b0, 0, 0, 0, 1'b0);

      // Reset while the read is on the bus: its matrix valid must never appear.
      chk("pre_abort_ready", 32'(bus.O_PIXEL_READY), 32'd1);
      bus.I_PIXEL = 8'h52;
      bus.I_PIXEL_VALID = 1'b1;
      @(negedge I_CLK);
      bus.I_PIXEL_VALID = 1'b0;
      chk("abort_wr_col", 32'(bus.O_COLUMN), 32'd2);
      chk("abort_wr_row", 32'(bus.O_ROW), 32'd0);
      @(negedge I_CLK);
      chk("abort_rd_en", 32'(bus.O_READ_ENABLE), 32'd1);
      chk("abort_rd_row", 32'(bus.O_ROW), 32'd2);
      I_RESET = 1'b0;
      #1;
      chk("abort_re_clr", 32'(bus.O_READ_ENABLE), 32'd0);
      chk("abort_mv0", 32'(bus.O_MATRIX_VALID), 32'd0);
      @(negedge I_CLK);
      chk("abort_mv1", 32'(bus.O_MATRIX_VALID), 32'd0);
      I_RESET = 1'b1;
      @(negedge I_CLK);
      chk("abort_mv2", 32'(bus.O_MATRIX_VALID), 32'd0);
      send(8'h60, 1'b0, 0, 0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
      send(8'h61, 1'b0, 1, 0, 1'b0, 1'b0, 0, 0, 0, 1'b0);

`ifdef FRAME_BUFFER_SCAN_SOF_EN
      do_reset();
      for (int i = 0; i < 5; i++)
         send(8'h70 + 8'(i), 1'b0, i % 4, i / 4, 1'b0, 1'b0, 0, 0, 0, 1'b0);
      send(8'h75, 1'b1, 0, 0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
      for (int i = 1; i < 9; i++)
         send(8'h80 + 8'(i), 1'b0, i % 4, i / 4, 1'b0, 1'b0, 0, 0, 0, 1'b0);
      // SOF at image row 2 truncates the frame and reports done.
      send(8'h90, 1'b1, 0, 0, 1'b1, 1'b0, 0, 0, 0, 1'b0);
      send(8'h91, 1'b0, 1, 0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
